spi_host_ctrl: RTL and testbench

//  CPU-facing register front end for spi_core. Buffers TX/RX bytes in small FIFOs,

---
 rtl/spi_host_ctrl_pkg.sv | 33 +++
 rtl/spi_host_ctrl_if.sv | 15 +
 rtl/spi_host_ctrl_fifo.sv | 46 ++++
 rtl/spi_host_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_host_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_host_ctrl_pkg.sv
// Shared definitions for the SPI host register front end: bus register addresses,
// STATUS/CTRL bit positions and the transaction FSM state encoding.
package spi_host_ctrl_pkg;

    localparam logic [1:0] AddrData   = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrCtrl   = 2'd2;
    localparam logic [1:0] AddrClkdiv = 2'd3;

    // STATUS bit positions
    localparam int unsigned StatTxFull     = 0;
    localparam int unsigned StatTxEmpty    = 1;
    localparam int unsigned StatRxFull     = 2;
    localparam int unsigned StatRxEmpty    = 3;
    localparam int unsigned StatXferActive = 4;
    localparam int unsigned StatRxOverrun  = 5;
    localparam int unsigned StatTxOverflow = 6;

    // CTRL bit positions
    localparam int unsigned CtrlCpol  = 0;
    localparam int unsigned CtrlCpha  = 1;
    localparam int unsigned CtrlRun   = 2;
    localparam int unsigned CtrlIrqEn = 3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitDone,
        StCapture
    } state_e;

endpackage

// File: rtl/spi_host_ctrl_if.sv
// 8-bit peripheral bus between the CPU side (master) and the SPI host controller (slave).
//   addr   2-bit register address      wr_en/rd_en  one-cycle strobes
//   wdata  write data                  rdata        registered read data (cycle after rd_en)
//   irq    level interrupt
interface spi_host_ctrl_if;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;

    modport master (output addr, wr_en, rd_en, wdata, input rdata, irq);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata, irq);
endinterface

// File: rtl/spi_host_ctrl_fifo.sv
// Synchronous show-ahead FIFO used for the TX and RX byte queues.
//   clock, reset_n   system clock, async active-low reset (pointers only)
//   push_i, wdata_i  write request and data; dropped when full unless a pop lands same cycle
//   pop_i            read request; ignored when empty
//   rdata_o          head entry, combinational
//   full_o, empty_o  occupancy flags
module spi_host_ctrl_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    parameter int unsigned Aw    = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    // One extra pointer bit distinguishes full from empty.
    logic [Aw:0]      wptr_q, rptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q[Aw-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + {{Aw{1'b0}}, 1'b1};
            if (do_pop)  rptr_q <= rptr_q + {{Aw{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q[Aw-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/spi_host_ctrl.sv
// CPU-facing register front end for spi_core. Queues TX/RX bytes, issues one-byte
// transactions to spi_core and captures the received byte when each one completes.
//   clock, reset_n      system clock, async active-low reset
//   bus                 peripheral bus (slave side): DATA/STATUS/CTRL/CLKDIV registers, irq
//   spi_enable_o        one-cycle start pulse to spi_core
//   spi_cpol_o/cpha_o   CTRL mode bits; spi_cont_o tied low
//   spi_clk_div_o       CLKDIV register
//   spi_tx_data_o       TX FIFO head
//   spi_busy_i          spi_core busy (high out of spi_core reset)
//   spi_rx_data_i       byte received by spi_core
module spi_host_ctrl
    import spi_host_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    spi_host_ctrl_if.slave        bus,
    output logic                  spi_enable_o,
    output logic                  spi_cpol_o,
    output logic                  spi_cpha_o,
    output logic                  spi_cont_o,
    output logic [7:0]            spi_clk_div_o,
    output logic [7:0]            spi_tx_data_o,
    input  logic                  spi_busy_i,
    input  logic [7:0]            spi_rx_data_i
);
    state_e     state_q, state_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic [7:0] clkdiv_q, clkdiv_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_overflow_q, tx_overflow_d;

    logic       wr_data, rd_data, wr_status;
    logic       tx_pop, rx_push;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic       xfer_active;
    logic [7:0] status;

    assign wr_data   = bus.wr_en && (bus.addr == AddrData);
    assign rd_data   = bus.rd_en && (bus.addr == AddrData);
    assign wr_status = bus.wr_en && (bus.addr == AddrStatus);
    assign tx_pop    = (state_q == StIssue);
    assign rx_push   = (state_q == StCapture);

    spi_host_ctrl_fifo #(.Width(8), .Depth(FIFO_DEPTH), .Aw(FIFO_AW)) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (wr_data),
        .wdata_i (bus.wdata),
        .pop_i   (tx_pop),
        .rdata_o (spi_tx_data_o),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    spi_host_ctrl_fifo #(.Width(8), .Depth(FIFO_DEPTH), .Aw(FIFO_AW)) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (rx_push),
        .wdata_i (spi_rx_data_i),
        .pop_i   (rd_data),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign xfer_active = (state_q != StIdle);
    assign status = {1'b0, tx_overflow_q, rx_overrun_q, xfer_active,
                     rx_empty, rx_full, tx_empty, tx_full};

    // Register writes, sticky flags (set wins over W1C) and read mux.
    always_comb begin
        ctrl_d        = ctrl_q;
        clkdiv_d      = clkdiv_q;
        rdata_d       = rdata_q;
        tx_overflow_d = tx_overflow_q;
        rx_overrun_d  = rx_overrun_q;

        if (bus.wr_en && (bus.addr == AddrCtrl))   ctrl_d   = bus.wdata[3:0];
        if (bus.wr_en && (bus.addr == AddrClkdiv)) clkdiv_d = bus.wdata;

        if (wr_status && bus.wdata[StatTxOverflow]) tx_overflow_d = 1'b0;
        if (wr_status && bus.wdata[StatRxOverrun])  rx_overrun_d  = 1'b0;
        if (wr_data && tx_full && !tx_pop)          tx_overflow_d = 1'b1;
        // RX full implies not empty, so a bus read here always frees a slot.
        if (rx_push && rx_full && !rd_data)         rx_overrun_d  = 1'b1;

        if (bus.rd_en) begin
            unique case (bus.addr)
                AddrData:   rdata_d = rx_empty ? 8'h00 : rx_head;
                AddrStatus: rdata_d = status;
                AddrCtrl:   rdata_d = {4'b0000, ctrl_q};
                default:    rdata_d = clkdiv_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        spi_enable_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ctrl_q[CtrlRun] && !tx_empty && !spi_busy_i) state_d = StIssue;
            end
            StIssue: begin
                spi_enable_o = 1'b1;
                state_d      = StWaitStart;
            end
            StWaitStart: if (spi_busy_i)  state_d = StWaitDone;
            StWaitDone:  if (!spi_busy_i) state_d = StCapture;
            StCapture:   state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            ctrl_q        <= '0;
            clkdiv_q      <= '0;
            rdata_q       <= '0;
            tx_overflow_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            clkdiv_q      <= clkdiv_d;
            rdata_q       <= rdata_d;
            tx_overflow_q <= tx_overflow_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.irq       = ctrl_q[CtrlIrqEn] & (!rx_empty | rx_overrun_q | (tx_empty & !xfer_active));
    assign spi_cpol_o    = ctrl_q[CtrlCpol];
    assign spi_cpha_o    = ctrl_q[CtrlCpha];
    assign spi_cont_o    = 1'b0;
    assign spi_clk_div_o = clkdiv_q;
endmodule

// File: tb/tb_spi_host_ctrl.sv
// Self-checking bench for spi_host_ctrl with a behavioural spi_core model that answers
// each byte with tx ^ 0xF0 after a fixed busy period.
module tb_spi_host_ctrl;
    logic       clock;
    logic       reset_n;
    logic       spi_enable, spi_cpol, spi_cpha, spi_cont;
    logic [7:0] spi_clk_div, spi_tx_data;
    logic       spi_busy;
    logic [7:0] spi_rx_data;
    logic       core_busy;
    logic       busy_force;

    int vectors;
    int miscompares;
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];

    spi_host_ctrl_if bus_if ();

    spi_host_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bus_if),
        .spi_enable_o  (spi_enable),
        .spi_cpol_o    (spi_cpol),
        .spi_cpha_o    (spi_cpha),
        .spi_cont_o    (spi_cont),
        .spi_clk_div_o (spi_clk_div),
        .spi_tx_data_o (spi_tx_data),
        .spi_busy_i    (spi_busy),
        .spi_rx_data_i (spi_rx_data)
    );

    assign spi_busy = core_busy | busy_force;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // spi_core model
    initial begin
        logic [7:0] tx;
        core_busy   = 1'b0;
        spi_rx_data = 8'h00;
        forever begin
            @(negedge clock);
            if (reset_n && spi_enable) begin
                tx        = spi_tx_data;
                core_busy = 1'b1;
                repeat (6) @(negedge clock);
                spi_rx_data = tx ^ 8'hF0;
                core_busy   = 1'b0;
            end
        end
    end

    // Scoreboard for issued bytes and pulse width
    initial begin
        logic       prev_en;
        logic [7:0] exp;
        prev_en = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n && spi_enable) begin
                vectors++;
                if (exp_tx_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL enable_unexpected: tx_data=%02h, no enable expected", spi_tx_data);
                end else begin
                    exp = exp_tx_q.pop_front();
                    if (spi_tx_data !== exp) begin
                        miscompares++;
                        $display("FAIL enable_tx_data: got %02h expected %02h", spi_tx_data, exp);
                    end
                end
                vectors++;
                if (prev_en) begin
                    miscompares++;
                    $display("FAIL enable_width: got 2+ cycles expected 1");
                end
            end
            prev_en = spi_enable;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clock);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wr_en = 1'b1;
        @(negedge clock);
        bus_if.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clock);
        bus_if.addr  = a;
        bus_if.rd_en = 1'b1;
        @(negedge clock);
        bus_if.rd_en = 1'b0;
        d = bus_if.rdata;
    endtask

    // Waits for all expected enables and the trailing capture; a timeout is a failure.
    task automatic wait_idle();
        int n = 0;
        while ((exp_tx_q.size() != 0 || spi_busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (12) @(negedge clock);
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL wait_idle_timeout: got %0d pending expected 0", exp_tx_q.size());
        end
    endtask

    task automatic read_data_expect(input string name);
        logic [7:0] got, exp;
        bus_read(2'd0, got);
        exp = (exp_rx_q.size() != 0) ? exp_rx_q.pop_front() : 8'h00;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic read_status_expect(input string name, input logic [7:0] exp);
        logic [7:0] got;
        bus_read(2'd1, got);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset_n      = 1'b0;
        busy_force   = 1'b1;
        bus_if.addr  = 2'd0;
        bus_if.wdata = 8'h00;
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({spi_enable, bus_if.irq, spi_cpol, spi_cpha, spi_cont} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl_bits: got %b expected 00000",
                     {spi_enable, bus_if.irq, spi_cpol, spi_cpha, spi_cont});
        end
        vectors++;
        if (bus_if.rdata !== 8'h00 || spi_clk_div !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_regs: got rdata=%02h clkdiv=%02h expected 00/00",
                     bus_if.rdata, spi_clk_div);
        end
        reset_n = 1'b1;
        @(negedge clock);
        read_status_expect("reset_status", 8'h0A);
        bus_read(2'd2, got);
        vectors++;
        if (got !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl_read: got %02h expected 00", got);
        end
    endtask

    task automatic test_busy_hold();
        int en_seen = 0;
        bus_write(2'd0, 8'hA5);
        bus_write(2'd2, 8'h04);
        repeat (10) begin
            @(negedge clock);
            if (spi_enable) en_seen++;
        end
        vectors++;
        if (en_seen != 0) begin
            miscompares++;
            $display("FAIL busy_hold_enable: got %0d enables expected 0", en_seen);
        end
        vectors++;
        if (spi_tx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL busy_hold_head: got %02h expected a5", spi_tx_data);
        end
        exp_tx_q.push_back(8'hA5);
        exp_rx_q.push_back(8'h55);
        busy_force = 1'b0;
        wait_idle();
        read_data_expect("busy_hold_rx");
        read_status_expect("busy_hold_status", 8'h0A);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            exp_tx_q.push_back(8'h11 + 8'(i));
            exp_rx_q.push_back(8'hE1 + 8'(i));
            bus_write(2'd0, 8'h11 + 8'(i));
        end
        wait_idle();
        for (int i = 0; i < 4; i++) read_data_expect("stream_rx");
        read_status_expect("stream_status", 8'h0A);
    endtask

    task automatic test_overflow();
        bus_write(2'd2, 8'h00);
        for (int i = 0; i < 5; i++) bus_write(2'd0, 8'h21 + 8'(i));
        // tx_full + tx_overflow, and RX is still empty from the previous test
        read_status_expect("overflow_status", 8'h49);
        bus_write(2'd1, 8'h40);
        read_status_expect("overflow_w1c", 8'h09);
    endtask

    task automatic test_rx_overrun();
        for (int i = 0; i < 4; i++) begin
            exp_tx_q.push_back(8'h21 + 8'(i));
            exp_rx_q.push_back(8'hD1 + 8'(i));
        end
        bus_write(2'd2, 8'h0C);
        repeat (4) @(negedge clock);
        exp_tx_q.push_back(8'h25);  // issued, but its reply is dropped
        bus_write(2'd0, 8'h25);
        wait_idle();
        read_status_expect("overrun_status", 8'h26);
        vectors++;
        if (bus_if.irq !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_irq: got %b expected 1", bus_if.irq);
        end
        for (int i = 0; i < 4; i++) read_data_expect("overrun_rx");
        read_status_expect("overrun_sticky", 8'h2A);
        bus_write(2'd1, 8'h20);
        read_status_expect("overrun_w1c", 8'h0A);
        bus_write(2'd2, 8'h00);
        @(negedge clock);
        vectors++;
        if (bus_if.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_disabled: got %b expected 0", bus_if.irq);
        end
    endtask

    task automatic test_stop_mid();
        int n = 0;
        for (int i = 0; i < 3; i++) bus_write(2'd0, 8'h31 + 8'(i));
        exp_tx_q.push_back(8'h31);
        exp_rx_q.push_back(8'hC1);
        bus_write(2'd2, 8'h04);
        while (!core_busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        bus_write(2'd2, 8'h00);
        wait_idle();
        repeat (20) @(negedge clock);
        read_status_expect("stop_status", 8'h00);
        read_data_expect("stop_rx");
        read_status_expect("stop_status_after", 8'h08);
    endtask

    task automatic test_empty_read();
        read_data_expect("empty_read");
        read_status_expect("empty_read_status", 8'h08);
        exp_tx_q.push_back(8'h32);
        exp_tx_q.push_back(8'h33);
        exp_rx_q.push_back(8'hC2);
        exp_rx_q.push_back(8'hC3);
        bus_write(2'd2, 8'h04);
        wait_idle();
        read_data_expect("empty_read_rx0");
        read_data_expect("empty_read_rx1");
        read_status_expect("empty_read_final", 8'h0A);
    endtask

    task automatic test_regs();
        logic [7:0] got;
        bus_write(2'd3, 8'h5A);
        bus_read(2'd3, got);
        vectors++;
        if (got !== 8'h5A || spi_clk_div !== 8'h5A) begin
            miscompares++;
            $display("FAIL clkdiv: got rd=%02h out=%02h expected 5a", got, spi_clk_div);
        end
        bus_write(2'd2, 8'hF3);
        bus_read(2'd2, got);
        vectors++;
        if (got !== 8'h03 || {spi_cpha, spi_cpol, spi_cont} !== 3'b110) begin
            miscompares++;
            $display("FAIL ctrl: got rd=%02h cpha/cpol/cont=%b expected 03/110",
                     got, {spi_cpha, spi_cpol, spi_cont});
        end
        bus_write(2'd2, 8'h00);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_busy_hold();
        test_stream();
        test_overflow();
        test_rx_overrun();
        test_stop_mid();
        test_empty_read();
        test_regs();
        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
